// File: rtl/kmeans_pkg.sv
// Shared widths, types and FSM states for the k-means centroid-update path.
package kmeans_pkg;

    localparam int centroid_num     = 8;
    localparam int cord_num         = 7;
    localparam int cordinate_width  = 13;
    localparam int accum_cord_width = 22;
    localparam int count_width      = 10;
    localparam int dataWidth        = cord_num * cordinate_width;
    localparam int accum_width      = cord_num * accum_cord_width;
    localparam int idx_width        = $clog2(centroid_num);

    typedef logic [cordinate_width-1:0]  cord_t;
    typedef logic [accum_cord_width-1:0] lane_t;
    typedef logic [count_width-1:0]      count_t;

    typedef cord_t [cord_num-1:0] point_t;
    typedef lane_t [cord_num-1:0] lanes_t;

    typedef struct packed {
        lanes_t lanes;
        count_t count;
    } entry_t;

    typedef enum logic {ACCUM, DRAIN} state_t;

endpackage

// File: rtl/accum_lane_add.sv
// One lane adder: zero-extended addend into an accumulator lane.
// ACCUM_SATURATE_EN selects clamp-at-max (with clamp flag) over wraparound.
module accum_lane_add
    import kmeans_pkg::*;
#(
    parameter int IN_W  = cordinate_width,
    parameter int SUM_W = accum_cord_width
) (
    input  logic [IN_W-1:0]  addend,
    input  logic [SUM_W-1:0] acc,
    output logic [SUM_W-1:0] sum,
    output logic             clamp
);

`ifdef ACCUM_SATURATE_EN
    logic [SUM_W:0] full;

    assign full  = {1'b0, acc} + {{(SUM_W+1-IN_W){1'b0}}, addend};
    assign clamp = full[SUM_W];
    assign sum   = clamp ? '1 : full[SUM_W-1:0];
`else
    assign clamp = 1'b0;
    assign sum   = acc + {{(SUM_W-IN_W){1'b0}}, addend};
`endif

endmodule

// File: rtl/centroid_accumulator.sv
// Per-centroid coordinate sums and point counts, drained in index order on flush.
// Optional macro ACCUM_SATURATE_EN: saturating lanes/counter with sticky overflow.
module centroid_accumulator
    import kmeans_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [dataWidth-1:0]   in_point,
    input  logic [idx_width-1:0]   in_cent_idx,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [idx_width-1:0]   out_idx,
    output logic [accum_width-1:0] accumulator,
    output logic [count_width-1:0] counter,
    output logic                   out_empty,
    output logic                   drain_done,
    output logic                   overflow
);

    localparam logic [idx_width:0]   cent_limit = (idx_width+1)'(centroid_num);
    localparam logic [idx_width-1:0] last_idx   = idx_width'(centroid_num - 1);

    state_t                state, state_nxt;
    logic [idx_width-1:0]  ptr, ptr_nxt;
    entry_t                entries [centroid_num];
    entry_t                entries_nxt [centroid_num];
    entry_t                sel, upd, shown;
    point_t                pt;
    logic [cord_num-1:0]   lane_clamp;
    logic                  cnt_clamp, clamp_any, hit;
    logic                  done_nxt, ovf_nxt;

    assign pt        = in_point;
    assign in_ready  = (state == ACCUM);
    assign hit       = in_valid && in_ready && ({1'b0, in_cent_idx} < cent_limit);
    assign sel       = entries[in_cent_idx];
    assign clamp_any = (|lane_clamp) | cnt_clamp;
    assign out_empty = (counter == '0);

    for (genvar k = 0; k < cord_num; k++) begin : g_lane
        accum_lane_add #(
            .IN_W  (cordinate_width),
            .SUM_W (accum_cord_width)
        ) u_lane (
            .addend (pt[k]),
            .acc    (sel.lanes[k]),
            .sum    (upd.lanes[k]),
            .clamp  (lane_clamp[k])
        );
    end

    accum_lane_add #(
        .IN_W  (1),
        .SUM_W (count_width)
    ) u_count (
        .addend (1'b1),
        .acc    (sel.count),
        .sum    (upd.count),
        .clamp  (cnt_clamp)
    );

    always_comb begin
        entries_nxt = entries;
        state_nxt   = state;
        ptr_nxt     = ptr;
        done_nxt    = 1'b0;
        ovf_nxt     = overflow;
        unique case (state)
            ACCUM: begin
                if (hit) begin
                    entries_nxt[in_cent_idx] = upd;
                    ovf_nxt = overflow | clamp_any;
                end
                if (flush) begin
                    state_nxt = DRAIN;
                    ptr_nxt   = '0;
                end
            end
            DRAIN: begin
                // out_valid is always high here, so out_ready alone completes a handshake
                if (out_ready) begin
                    entries_nxt[ptr] = '0;
                    ptr_nxt = ptr + 1'b1;
                    if (ptr == last_idx) begin
                        state_nxt = ACCUM;
                        ptr_nxt   = '0;
                        done_nxt  = 1'b1;
                        ovf_nxt   = 1'b0;
                    end
                end
            end
        endcase
        // Output registers load from next-state so a same-cycle point is visible
        shown = entries_nxt[ptr_nxt];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ACCUM;
            ptr         <= '0;
            entries     <= '{default: '0};
            out_valid   <= 1'b0;
            out_idx     <= '0;
            accumulator <= '0;
            counter     <= '0;
            drain_done  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            entries     <= entries_nxt;
            out_valid   <= (state_nxt == DRAIN);
            out_idx     <= ptr_nxt;
            accumulator <= shown.lanes;
            counter     <= shown.count;
            drain_done  <= done_nxt;
            overflow    <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_centroid_accumulator.sv
// Directed bench for centroid_accumulator: table-driven drains plus corner sequences.
module tb_centroid_accumulator;
    import kmeans_pkg::*;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [dataWidth-1:0]   in_point;
    logic [idx_width-1:0]   in_cent_idx;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [idx_width-1:0]   out_idx;
    logic [accum_width-1:0] accumulator;
    logic [count_width-1:0] counter;
    logic                   out_empty;
    logic                   drain_done;
    logic                   overflow;

    centroid_accumulator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_point    (in_point),
        .in_cent_idx (in_cent_idx),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_idx     (out_idx),
        .accumulator (accumulator),
        .counter     (counter),
        .out_empty   (out_empty),
        .drain_done  (drain_done),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        point_t               p;
        logic [idx_width-1:0] idx;
        logic                 fl;
    } pt_rec_t;

    typedef struct {
        lanes_t lanes;
        count_t cnt;
    } drec_t;

`ifdef ACCUM_SATURATE_EN
    localparam bit sat = 1'b1;
`else
    localparam bit sat = 1'b0;
`endif

    int      vectors = 0;
    int      fails   = 0;
    pt_rec_t pts [4];
    drec_t   exp_tab [centroid_num];
    point_t  p0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
        vectors++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    function automatic point_t fill(input int v);
        point_t r;
        for (int k = 0; k < cord_num; k++) r[k] = cordinate_width'(v);
        return r;
    endfunction

    function automatic lanes_t lfill(input int v);
        lanes_t r;
        for (int k = 0; k < cord_num; k++) r[k] = accum_cord_width'(v);
        return r;
    endfunction

    task automatic send(input point_t p, input logic [idx_width-1:0] idx, input logic fl);
        in_valid    = 1'b1;
        in_point    = p;
        in_cent_idx = idx;
        flush       = fl;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        in_point = '0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < centroid_num; i++) begin
            exp_tab[i].lanes = '0;
            exp_tab[i].cnt   = '0;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk($sformatf("%s in_ready", tag), in_ready, 1);
        chk($sformatf("%s out_valid", tag), out_valid, 0);
        chk($sformatf("%s out_idx", tag), out_idx, 0);
        chk($sformatf("%s accumulator", tag), accumulator, 0);
        chk($sformatf("%s counter", tag), counter, 0);
        chk($sformatf("%s out_empty", tag), out_empty, 1);
        chk($sformatf("%s drain_done", tag), drain_done, 0);
        chk($sformatf("%s overflow", tag), overflow, 0);
    endtask

    task automatic drain_all(input string tag, input int hold_at);
        int n;
        for (int i = 0; i < centroid_num; i++) begin
            n = 0;
            while (!out_valid && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("%s[%0d] out_valid", tag, i), out_valid, 1);
            if (i == 0) chk($sformatf("%s in_ready low", tag), in_ready, 0);
            chk($sformatf("%s[%0d] out_idx", tag, i), out_idx, i);
            chk($sformatf("%s[%0d] accumulator", tag, i), accumulator, exp_tab[i].lanes);
            chk($sformatf("%s[%0d] counter", tag, i), counter, exp_tab[i].cnt);
            chk($sformatf("%s[%0d] out_empty", tag, i), out_empty, exp_tab[i].cnt == 0);
            if (i == hold_at) begin
                out_ready = 1'b0;
                repeat (5) begin
                    tick();
                    chk($sformatf("%s hold valid", tag), out_valid, 1);
                    chk($sformatf("%s hold idx", tag), out_idx, i);
                    chk($sformatf("%s hold acc", tag), accumulator, exp_tab[i].lanes);
                    chk($sformatf("%s hold cnt", tag), counter, exp_tab[i].cnt);
                    chk($sformatf("%s hold done", tag), drain_done, 0);
                end
                out_ready = 1'b1;
            end
            tick();
        end
        chk($sformatf("%s drain_done", tag), drain_done, 1);
        chk($sformatf("%s in_ready after", tag), in_ready, 1);
        chk($sformatf("%s out_valid after", tag), out_valid, 0);
        chk($sformatf("%s overflow cleared", tag), overflow, 0);
        tick();
        chk($sformatf("%s drain_done pulse", tag), drain_done, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pts[0] = '{fill(100), 3'd2, 1'b0};
        pts[1] = '{fill(100), 3'd2, 1'b0};
        pts[2] = '{fill(100), 3'd2, 1'b0};
        for (int k = 0; k < cord_num; k++) pts[3].p[k] = cordinate_width'(k + 1);
        pts[3].idx = 3'd5;
        pts[3].fl  = 1'b1;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_point    = '0;
        in_cent_idx = '0;
        flush       = 1'b0;
        out_ready   = 1'b1;
        repeat (3) tick();
        chk_idle("reset");
        rst_n = 1'b1;
        tick();

        // Three back-to-back points into entry 2, then a drain with a stall at 3
        for (int r = 0; r < 3; r++) send(pts[r].p, pts[r].idx, pts[r].fl);
        pulse_flush();
        clear_exp();
        exp_tab[2].lanes = lfill(300);
        exp_tab[2].cnt   = 10'd3;
        drain_all("A", 3);

        // Point accepted in the same cycle as flush
        send(pts[3].p, pts[3].idx, pts[3].fl);
        clear_exp();
        for (int k = 0; k < cord_num; k++) exp_tab[5].lanes[k] = accum_cord_width'(k + 1);
        exp_tab[5].cnt = 10'd1;
        drain_all("B", -1);

        // Lane 0 of entry 0 to 4194000, then push past 2^22-1
        p0    = '0;
        p0[0] = 13'd8191;
        repeat (512) send(p0, 3'd0, 1'b0);
        p0[0] = 13'd208;
        send(p0, 3'd0, 1'b0);
        chk("C overflow before", overflow, 0);
        p0[0] = 13'd8191;
        send(p0, 3'd0, 1'b0);
        chk("C overflow", overflow, sat);
        pulse_flush();
        clear_exp();
        exp_tab[0].lanes[0] = sat ? 22'd4194303 : 22'd7887;
        exp_tab[0].cnt      = 10'd514;
        drain_all("C", -1);

        // Counter boundary: 1024 points into entry 7
        repeat (1023) send('0, 3'd7, 1'b0);
        chk("D overflow at max", overflow, 0);
        send('0, 3'd7, 1'b0);
        chk("D overflow", overflow, sat);
        pulse_flush();
        clear_exp();
        exp_tab[7].cnt = sat ? 10'd1023 : 10'd0;
        drain_all("D", -1);

        // Reset in the middle of a drain
        send(fill(5), 3'd6, 1'b0);
        pulse_flush();
        for (int i = 0; i < 4; i++) begin
            chk("E pre idx", out_idx, i);
            tick();
        end
        chk("E at idx4", out_idx, 4);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_idle("E after reset");
        tick();
        pulse_flush();
        clear_exp();
        drain_all("E", -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
